rx_control: RTL and testbench

RX_CONTROL -- requirements
Module: rx_control

---
 rtl/rx_control.sv | 164 ++++++++++++++++
 tb/tb_rx_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_control.sv
// USB-style receive controller: sync/PID checking, payload write strobes
// and error tracking for one packet at a time.
//
// Ports:
//   clk, n_rst     clock, async active-low reset
//   d_edge         packet start pulse (honoured in IDLE and ERR only)
//   eop            end-of-packet, qualified by shift_enable
//   shift_enable   bit-sample strobe
//   byte_received  pulse, rcv_data holds a complete byte
//   rcv_data[7:0]  received byte
//   rcving         packet reception in progress
//   w_enable       one-cycle FIFO push of rcv_data
//   r_error        receive-error flag, held until the next packet start
//   rx_pid[3:0]    last legal PID
//   pid_valid      pulse when rx_pid is updated
//   data_count     payload bytes written this packet (0..64)
module rx_control (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [3:0] rx_pid,
  output logic       pid_valid,
  output logic [6:0] data_count
);

  typedef enum logic [3:0] {
    IDLE,
    SYNC_WAIT,
    CHK_SYNC,
    PID_WAIT,
    CHK_PID,
    DATA_WAIT,
    STORE,
    EOP_WAIT,
    DONE,
    ERR_WAIT,
    ERR
  } state_t;

  localparam logic [6:0] MAX_BYTES = 7'd64;

  state_t state;
  state_t next_state;

  logic pkt_end;
  logic pid_ok;
  logic pid_data;
  logic pid_legal;
  logic start;
  logic store_wr;

  assign pkt_end = eop & shift_enable;

  // PID nibble class; the upper nibble must be its complement
  always_comb begin
    pid_ok   = 1'b0;
    pid_data = 1'b0;
    case (rcv_data[3:0])
      4'b0001, 4'b1001, 4'b0011, 4'b1011: begin
        pid_ok   = 1'b1;
        pid_data = 1'b1;
      end
      4'b0010, 4'b1010, 4'b1110: begin
        pid_ok = 1'b1;
      end
      default: begin
        pid_ok = 1'b0;
      end
    endcase
  end

  assign pid_legal = pid_ok & (rcv_data[7:4] == ~rcv_data[3:0]);

  assign start = d_edge & ((state == IDLE) | (state == ERR));
  assign store_wr = (state == STORE) & (data_count < MAX_BYTES);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (d_edge) next_state = SYNC_WAIT;
      end
      SYNC_WAIT: begin
        if (pkt_end) next_state = ERR;
        else if (byte_received) next_state = CHK_SYNC;
      end
      CHK_SYNC: begin
        if (rcv_data == 8'h80) next_state = PID_WAIT;
        else next_state = ERR_WAIT;
      end
      PID_WAIT: begin
        if (pkt_end) next_state = ERR;
        else if (byte_received) next_state = CHK_PID;
      end
      CHK_PID: begin
        if (!pid_legal) next_state = ERR_WAIT;
        else if (pid_data) next_state = DATA_WAIT;
        else next_state = EOP_WAIT;
      end
      DATA_WAIT: begin
        if (pkt_end) next_state = DONE;
        else if (byte_received) next_state = STORE;
      end
      STORE: begin
        if (data_count < MAX_BYTES) next_state = DATA_WAIT;
        else next_state = ERR_WAIT;
      end
      EOP_WAIT: begin
        if (pkt_end) next_state = DONE;
        else if (byte_received) next_state = ERR_WAIT;
      end
      DONE: begin
        next_state = IDLE;
      end
      ERR_WAIT: begin
        if (pkt_end) next_state = ERR;
      end
      ERR: begin
        if (d_edge) next_state = SYNC_WAIT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_count <= '0;
      rx_pid     <= 4'h0;
      pid_valid  <= 1'b0;
    end else begin
      if (start) begin
        data_count <= '0;
      end else if (store_wr) begin
        data_count <= data_count + 7'd1;
      end
      if ((state == CHK_PID) && pid_legal) begin
        rx_pid <= rcv_data[3:0];
      end
      pid_valid <= (state == CHK_PID) & pid_legal;
    end
  end

  assign rcving = (state != IDLE) & (state != DONE) & (state != ERR);
  assign r_error = (state == ERR_WAIT) | (state == ERR);
  assign w_enable = store_wr;

endmodule

// File: tb/tb_rx_control.sv
// Directed bench for rx_control: cycle-by-cycle vector table plus
// overlength and mid-packet reset sequences.
module tb_rx_control;

  logic       clk;
  logic       n_rst;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [3:0] rx_pid;
  logic       pid_valid;
  logic [6:0] data_count;

  rx_control dut (
    .clk(clk),
    .n_rst(n_rst),
    .d_edge(d_edge),
    .eop(eop),
    .shift_enable(shift_enable),
    .byte_received(byte_received),
    .rcv_data(rcv_data),
    .rcving(rcving),
    .w_enable(w_enable),
    .r_error(r_error),
    .rx_pid(rx_pid),
    .pid_valid(pid_valid),
    .data_count(data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       de;
    logic       eop;
    logic       se;
    logic       br;
    logic [7:0] d;
    logic       rcv;
    logic       we;
    logic       err;
    logic [3:0] pid;
    logic       pv;
    logic [6:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   dbl = 0;
  int   we_cnt = 0;
  logic prev_we = 1'b0;
  logic prev_pv = 1'b0;

  task automatic add(input logic de, input logic e, input logic se,
                     input logic br, input logic [7:0] d,
                     input logic rcv, input logic we, input logic err,
                     input logic [3:0] pid, input logic pv,
                     input logic [6:0] cnt);
    vec_t v;
    v.de = de; v.eop = e; v.se = se; v.br = br; v.d = d;
    v.rcv = rcv; v.we = we; v.err = err;
    v.pid = pid; v.pv = pv; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [14:0] outs();
    return {rcving, w_enable, r_error, rx_pid, pid_valid, data_count};
  endfunction

  // drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic de, input logic e, input logic se,
                     input logic br, input logic [7:0] d);
    d_edge = de; eop = e; shift_enable = se;
    byte_received = br; rcv_data = d;
    @(posedge clk);
    #1;
    if ((w_enable && prev_we) || (pid_valid && prev_pv)) dbl++;
    prev_we = w_enable;
    prev_pv = pid_valid;
    if (w_enable) we_cnt++;
  endtask

  initial begin
    n_rst = 1'b0;
    d_edge = 0; eop = 0; shift_enable = 0;
    byte_received = 0; rcv_data = 8'h00;

    // clean DATA0 with two payload bytes
    add(1,0,0,0,8'h00, 1,0,0,4'h0,0,0);
    add(0,0,0,1,8'h80, 1,0,0,4'h0,0,0);
    add(0,0,0,0,8'h80, 1,0,0,4'h0,0,0);
    add(0,1,0,0,8'h80, 1,0,0,4'h0,0,0);
    add(0,0,0,1,8'hC3, 1,0,0,4'h0,0,0);
    add(0,0,0,0,8'hC3, 1,0,0,4'h3,1,0);
    add(0,0,0,1,8'h11, 1,1,0,4'h3,0,0);
    add(1,0,0,0,8'h11, 1,0,0,4'h3,0,1);
    add(0,0,0,1,8'h22, 1,1,0,4'h3,0,1);
    add(0,0,0,0,8'h22, 1,0,0,4'h3,0,2);
    add(0,1,1,1,8'h22, 0,0,0,4'h3,0,2);
    add(0,0,0,0,8'h22, 0,0,0,4'h3,0,2);
    add(0,0,0,1,8'h80, 0,0,0,4'h3,0,2);
    // bad sync byte
    add(1,0,0,0,8'h80, 1,0,0,4'h3,0,0);
    add(0,0,0,1,8'h81, 1,0,0,4'h3,0,0);
    add(0,0,0,0,8'h81, 1,0,1,4'h3,0,0);
    add(0,0,0,1,8'h55, 1,0,1,4'h3,0,0);
    add(1,0,0,0,8'h55, 1,0,1,4'h3,0,0);
    add(0,1,1,0,8'h55, 0,0,1,4'h3,0,0);
    add(0,1,0,1,8'h55, 0,0,1,4'h3,0,0);
    // bad PID: check nibble mismatch
    add(1,0,0,0,8'h55, 1,0,0,4'h3,0,0);
    add(0,0,0,1,8'h80, 1,0,0,4'h3,0,0);
    add(0,0,0,0,8'h80, 1,0,0,4'h3,0,0);
    add(0,0,0,1,8'hC2, 1,0,0,4'h3,0,0);
    add(0,0,0,0,8'hC2, 1,0,1,4'h3,0,0);
    add(0,1,1,0,8'hC2, 0,0,1,4'h3,0,0);
    // bad PID: complement ok, nibble not in the set
    add(1,0,0,0,8'hC2, 1,0,0,4'h3,0,0);
    add(0,0,0,1,8'h80, 1,0,0,4'h3,0,0);
    add(0,0,0,0,8'h80, 1,0,0,4'h3,0,0);
    add(0,0,0,1,8'hF0, 1,0,0,4'h3,0,0);
    add(0,0,0,0,8'hF0, 1,0,1,4'h3,0,0);
    add(0,1,1,0,8'hF0, 0,0,1,4'h3,0,0);
    // ACK handshake
    add(1,0,0,0,8'hF0, 1,0,0,4'h3,0,0);
    add(0,0,0,1,8'h80, 1,0,0,4'h3,0,0);
    add(0,0,0,0,8'h80, 1,0,0,4'h3,0,0);
    add(0,0,0,1,8'hD2, 1,0,0,4'h3,0,0);
    add(0,0,0,0,8'hD2, 1,0,0,4'h2,1,0);
    add(0,0,0,0,8'hD2, 1,0,0,4'h2,0,0);
    add(0,1,1,0,8'hD2, 0,0,0,4'h2,0,0);
    add(0,0,0,0,8'hD2, 0,0,0,4'h2,0,0);
    // STALL followed by an illegal extra byte
    add(1,0,0,0,8'hD2, 1,0,0,4'h2,0,0);
    add(0,0,0,1,8'h80, 1,0,0,4'h2,0,0);
    add(0,0,0,0,8'h80, 1,0,0,4'h2,0,0);
    add(0,0,0,1,8'h1E, 1,0,0,4'h2,0,0);
    add(0,0,0,0,8'h1E, 1,0,0,4'hE,1,0);
    add(0,0,0,1,8'h33, 1,0,1,4'hE,0,0);
    add(0,1,1,0,8'h33, 0,0,1,4'hE,0,0);
    // end beats byte in SYNC_WAIT
    add(1,0,0,0,8'h33, 1,0,0,4'hE,0,0);
    add(0,1,1,1,8'h80, 0,0,1,4'hE,0,0);

    #12;
    chk("reset_outputs", 32'(outs()), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].de, vecs[i].eop, vecs[i].se, vecs[i].br, vecs[i].d);
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vecs[i].rcv, vecs[i].we, vecs[i].err, vecs[i].pid,
               vecs[i].pv, vecs[i].cnt}));
    end

    // overlength DATA1: 65 payload bytes
    cyc(1,0,0,0,8'h00);
    cyc(0,0,0,1,8'h80);
    cyc(0,0,0,0,8'h80);
    cyc(0,0,0,1,8'h4B);
    cyc(0,0,0,0,8'h4B);
    chk("ovl_pid", 32'(rx_pid), 32'hB);
    we_cnt = 0;
    for (int i = 0; i < 65; i++) begin
      cyc(0,0,0,1,8'(i));
      cyc(0,0,0,0,8'(i));
    end
    chk("ovl_we_pulses", 32'(we_cnt), 32'd64);
    chk("ovl_count", 32'(data_count), 32'd64);
    chk("ovl_error", 32'(r_error), 32'd1);
    chk("ovl_rcving", 32'(rcving), 32'd1);
    cyc(0,1,1,0,8'h00);
    chk("ovl_err_state", 32'({rcving, r_error}), 32'b01);

    // reset in the middle of a payload write
    cyc(1,0,0,0,8'h00);
    cyc(0,0,0,1,8'h80);
    cyc(0,0,0,0,8'h80);
    cyc(0,0,0,1,8'hC3);
    cyc(0,0,0,0,8'hC3);
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,0,1,8'(8'h10 + i));
      cyc(0,0,0,0,8'(8'h10 + i));
    end
    chk("pre_rst_count", 32'(data_count), 32'd3);
    cyc(0,0,0,1,8'h44);
    chk("pre_rst_we", 32'(w_enable), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'(outs()), 32'h0);
    we_cnt = 0;
    cyc(0,0,0,0,8'h44);
    cyc(0,0,0,1,8'h55);
    chk("rst_held_outputs", 32'(outs()), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("rst_no_we", 32'(we_cnt), 32'd0);

    // clean DATA1 packet after reset
    we_cnt = 0;
    cyc(1,0,0,0,8'h00);
    cyc(0,0,0,1,8'h80);
    cyc(0,0,0,0,8'h80);
    cyc(0,0,0,1,8'h4B);
    cyc(0,0,0,0,8'h4B);
    chk("post_pid", 32'({rx_pid, pid_valid}), 32'({4'hB, 1'b1}));
    cyc(0,0,0,1,8'hA5);
    cyc(0,0,0,0,8'hA5);
    cyc(0,1,1,0,8'hA5);
    chk("post_done", 32'({rcving, r_error, data_count}), 32'd1);
    chk("post_we", 32'(we_cnt), 32'd1);
    cyc(0,0,0,0,8'hA5);
    chk("post_idle", 32'(outs()), 32'({7'b0001011, 1'b0, 7'd1}));

    chk("no_double_pulse", 32'(dbl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
